// File: rtl/scanner_pkg.sv
// rtl/scanner_pkg.sv - shared state encoding and width helpers for the coverage scanner
// Purpose: scan FSM state type plus width helpers for coordinate, counter and id buses.
// Ports: none (package).
package scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_t;

  // Bits needed to count 0..w*h inclusive, so a full frame never wraps.
  function automatic int cnt_bits(input int w, input int h);
    return $clog2(w * h + 1);
  endfunction

  // Bits needed to index 0..n-1; at least one bit so degenerate sizes stay legal.
  function automatic int coord_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/coverage_scanner_if.sv
// rtl/coverage_scanner_if.sv - coordinate/coverage bus between scanner and coverage datapath
// Purpose: carries issued pixel coordinates out and per-shape coverage back.
// Ports: px_valid, px_x, px_y (scanner -> datapath); en_in (datapath -> scanner).
// Modports: master = scanner side, slave = coverage datapath side.
interface coverage_scanner_if
  import scanner_pkg::*;
#(
  parameter int MAXSHP = 16,
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) ();

  localparam int XW = coord_bits(WIDTH);
  localparam int YW = coord_bits(HEIGHT);

  logic              px_valid;
  logic [XW-1:0]     px_x;
  logic [YW-1:0]     px_y;
  logic [MAXSHP-1:0] en_in;

  modport master (output px_valid, output px_x, output px_y, input en_in);
  modport slave  (input px_valid, input px_x, input px_y, output en_in);

endinterface

// File: rtl/pixel_selector.sv
// rtl/pixel_selector.sv - decodes a shape-enable vector into overlap, black and lowest-id flags
// Purpose: classify one pixel's shape coverage.
// Ports: en (shape enables in); multiple (>=2 set), black (none set), id (lowest set index).
module pixel_selector
  import scanner_pkg::*;
#(
  parameter int MAXSHP = 16
) (
  input  logic [MAXSHP-1:0]                 en,
  output logic                              multiple,
  output logic                              black,
  output logic [coord_bits(MAXSHP)-1:0]     id
);

  localparam int IDW = coord_bits(MAXSHP);
  localparam logic [MAXSHP-1:0] ONE = MAXSHP'(1);

  assign black = (en == '0);

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multiple = ((en & (en - ONE)) != '0);

  always_comb begin
    id = '0;
    for (int i = MAXSHP - 1; i >= 0; i--) begin
      if (en[i]) id = IDW'(i);
    end
  end

endmodule

// File: rtl/coverage_scanner.sv
// rtl/coverage_scanner.sv - raster-scans a frame and counts covered and overlapping pixels
// Purpose: issue every pixel once in raster order, accumulate coverage returned LAT cycles later.
// Ports: clk, rst (sync active-high); start, hold, target_area (control in);
//        px (coverage bus, master); busy, done, covered_cnt, overlap_cnt, solved (status out).
module coverage_scanner
  import scanner_pkg::*;
#(
  parameter  int MAXSHP = 16,
  parameter  int WIDTH  = 640,
  parameter  int HEIGHT = 480,
  parameter  int LAT    = 2,
  localparam int CW     = cnt_bits(WIDTH, HEIGHT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                hold,
  input  logic [CW-1:0]       target_area,
  coverage_scanner_if.master  px,
  output logic                busy,
  output logic                done,
  output logic [CW-1:0]       covered_cnt,
  output logic [CW-1:0]       overlap_cnt,
  output logic                solved
);

  localparam int XW = coord_bits(WIDTH);
  localparam int YW = coord_bits(HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  scan_state_t   state, state_nx;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [LAT-1:0] dly;
  logic [LAT-1:0] dly_sh;
  logic [CW-1:0] tgt_q;
  logic          sol_valid;
  logic          issue, last_px, dv;
  logic          multiple, black;

  assign issue   = (state == ST_SCAN) && !hold;
  assign last_px = (x_q == X_LAST) && (y_q == Y_LAST);
  // Oldest tap lines up with the en_in returned for that issue.
  assign dv      = dly[LAT-1];
  // Delay line contents after the next shift, ignoring any new issue.
  assign dly_sh  = dly << 1;

  assign px.px_valid = issue;
  assign px.px_x     = x_q;
  assign px.px_y     = y_q;

  pixel_selector #(.MAXSHP(MAXSHP)) u_sel (
    .en       (px.en_in),
    .multiple (multiple),
    .black    (black),
    .id       ()
  );

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_SCAN;
      end
      ST_SCAN: begin
        busy = 1'b1;
        if (issue && last_px) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (dly_sh == '0) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      dly         <= '0;
      tgt_q       <= '0;
      covered_cnt <= '0;
      overlap_cnt <= '0;
      sol_valid   <= 1'b0;
    end else begin
      state <= state_nx;
      dly   <= dly_sh | LAT'(issue);

      if (state == ST_IDLE && start) begin
        x_q         <= '0;
        y_q         <= '0;
        tgt_q       <= target_area;
        covered_cnt <= '0;
        overlap_cnt <= '0;
        sol_valid   <= 1'b0;
      end else begin
        if (dv) begin
          covered_cnt <= covered_cnt + CW'(!black);
          overlap_cnt <= overlap_cnt + CW'(multiple);
        end
        if (state == ST_DRAIN && state_nx == ST_DONE) sol_valid <= 1'b1;
      end

      if (issue) begin
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= (y_q == Y_LAST) ? '0 : y_q + YW'(1);
        end else begin
          x_q <= x_q + XW'(1);
        end
      end
    end
  end

  // solved reads the final counts once the frame has fully drained.
  assign solved = sol_valid && (overlap_cnt == '0) && (covered_cnt == tgt_q);

endmodule
